nonce_sweep_ctrl: RTL and testbench

//  Sequences the two-pass SHA-256 hash core across a nonce range for one 80-byte padded header.

---
 rtl/nonce_sweep_ctrl_pkg.sv | 16 +
 rtl/nonce_sweep_ctrl_lz_check.sv | 14 +
 rtl/nonce_sweep_ctrl.sv | 128 ++++++++++++
 tb/tb_nonce_sweep_ctrl.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/nonce_sweep_ctrl_pkg.sv
// nonce_sweep_ctrl_pkg: shared constants, FSM encoding and target clamp for the nonce sweeper.
package nonce_sweep_ctrl_pkg;
    localparam logic [6:0] LAST_SEL  = 7'd64;
    localparam logic [4:0] NONCE_IDX = 5'd19;
    localparam logic [6:0] MAX_LZ    = 7'd64;
    localparam int         HDR_WORDS = 32;
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_BLK0  = 3'd1;
    localparam logic [2:0] S_BLK1  = 3'd2;
    localparam logic [2:0] S_BLK2  = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    function automatic logic [6:0] clamp_lz(input logic [6:0] lz);
        return (lz > MAX_LZ) ? MAX_LZ : lz;
    endfunction
endpackage

// File: rtl/nonce_sweep_ctrl_lz_check.sv
// nonce_sweep_ctrl_lz_check: hit when the top target_lz bits of {h1,h2} are all zero.
module nonce_sweep_ctrl_lz_check
    import nonce_sweep_ctrl_pkg::*;
(
    input  logic [31:0] i_h1,
    input  logic [31:0] i_h2,
    input  logic [6:0]  i_target_lz,
    output logic        o_hit
);
    logic [63:0] w_mask;
    // A shift by 64 clears the mask, so a zero target always hits.
    assign w_mask = {64{1'b1}} << (7'd64 - clamp_lz(i_target_lz));
    assign o_hit  = ~|({i_h1, i_h2} & w_mask);
endmodule

// File: rtl/nonce_sweep_ctrl.sv
// nonce_sweep_ctrl: sequences the two-pass hash core across a nonce range and reports the first hit.
module nonce_sweep_ctrl
    import nonce_sweep_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_hdr_we,
    input  logic [4:0]  i_hdr_addr,
    input  logic [31:0] i_hdr_wdata,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic [31:0] i_nonce_first,
    input  logic [31:0] i_nonce_last,
    input  logic [6:0]  i_target_lz,
    input  logic [31:0] i_h1,
    input  logic [31:0] i_h2,
    output logic [1:0]  o_hash_block,
    output logic [6:0]  o_hash_select,
    output logic [31:0] o_msg_word,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_found,
    output logic        o_aborted,
    output logic [31:0] o_found_nonce,
    output logic [31:0] o_cur_nonce
);
    logic [2:0]  r_state;
    logic [6:0]  r_sel;
    logic [31:0] r_nonce;
    logic [31:0] r_last;
    logic [6:0]  r_target;
    logic [31:0] r_msg;
    logic        r_found;
    logic        r_aborted;
    logic [31:0] r_found_nonce;
    logic [31:0] r_buf [HDR_WORDS];
    logic [2:0]  w_nxt_state;
    logic [6:0]  w_nxt_sel;
    logic [31:0] w_nxt_nonce;
    logic [31:0] w_nxt_msg;
    logic [4:0]  w_idx;
    logic        w_hit;
    logic        w_busy;
    logic        w_blk_end;

    nonce_sweep_ctrl_lz_check u_lz_check (
        .i_h1       (i_h1),
        .i_h2       (i_h2),
        .i_target_lz(r_target),
        .o_hit      (w_hit)
    );

    assign w_busy    = (r_state >= S_BLK0) && (r_state <= S_CHECK);
    assign w_blk_end = i_stop || (r_sel == LAST_SEL);

    always_comb begin
        w_nxt_state = r_state;
        w_nxt_sel   = '0;
        w_nxt_nonce = r_nonce;
        case (r_state)
            S_IDLE: begin
                w_nxt_state = i_start ? S_BLK0 : S_IDLE;
                w_nxt_nonce = i_start ? i_nonce_first : r_nonce;
            end
            S_BLK0, S_BLK1, S_BLK2: begin
                w_nxt_sel   = w_blk_end ? 7'd0 : r_sel + 7'd1;
                w_nxt_state = i_stop ? S_DONE : (r_sel == LAST_SEL) ? r_state + 3'd1 : r_state;
            end
            S_CHECK: begin
                w_nxt_state = (w_hit || i_stop || r_nonce == r_last) ? S_DONE : S_BLK0;
                w_nxt_nonce = (w_nxt_state == S_BLK0) ? r_nonce + 32'd1 : r_nonce;
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // The message word is precomputed from next state/select so it lands aligned with them.
    assign w_idx     = {w_nxt_state == S_BLK1, w_nxt_sel[3:0]};
    assign w_nxt_msg = (w_nxt_state == S_BLK1 && w_idx == NONCE_IDX) ? w_nxt_nonce :
                       (w_nxt_state == S_BLK0 || w_nxt_state == S_BLK1) ? r_buf[w_idx] : 32'd0;

    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && i_hdr_we)
            r_buf[i_hdr_addr] <= i_hdr_wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_sel         <= '0;
            r_nonce       <= '0;
            r_last        <= '0;
            r_target      <= '0;
            r_msg         <= '0;
            r_found       <= 1'b0;
            r_aborted     <= 1'b0;
            r_found_nonce <= '0;
        end else begin
            r_state <= w_nxt_state;
            r_sel   <= w_nxt_sel;
            r_nonce <= w_nxt_nonce;
            r_msg   <= w_nxt_msg;
            if (r_state == S_IDLE && i_start) begin
                r_last        <= i_nonce_last;
                r_target      <= i_target_lz;
                r_found       <= 1'b0;
                r_aborted     <= 1'b0;
                r_found_nonce <= '0;
            end
            if (r_state == S_CHECK && w_hit) begin
                r_found       <= 1'b1;
                r_found_nonce <= r_nonce;
            end else if (w_busy && i_stop) begin
                r_aborted <= 1'b1;
            end
        end
    end

    assign o_hash_block  = (r_state == S_BLK1) ? 2'd1 : (r_state == S_BLK2) ? 2'd2 : 2'd0;
    assign o_hash_select = r_sel;
    assign o_msg_word    = r_msg;
    assign o_busy        = w_busy;
    assign o_done        = (r_state == S_DONE);
    assign o_found       = r_found;
    assign o_aborted     = r_aborted;
    assign o_found_nonce = r_found_nonce;
    assign o_cur_nonce   = r_nonce;
endmodule

// File: tb/tb_nonce_sweep_ctrl.sv
// tb_nonce_sweep_ctrl: directed and random sweeps checked against a cycle/arithmetic reference model.
module tb_nonce_sweep_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        hdr_we = 1'b0;
    logic [4:0]  hdr_addr = '0;
    logic [31:0] hdr_wdata = '0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [31:0] nf = '0;
    logic [31:0] nl = '0;
    logic [6:0]  tlz = '0;
    logic [31:0] h1, h2;
    logic [1:0]  o_hash_block;
    logic [6:0]  o_hash_select;
    logic [31:0] o_msg_word;
    logic        o_busy, o_done, o_found, o_aborted;
    logic [31:0] o_found_nonce, o_cur_nonce;
    int          n_chk = 0;
    int          n_fail = 0;
    int          dmode = 0;
    logic [31:0] key = '0;
    logic [31:0] bufm [32];

    nonce_sweep_ctrl dut (
        .clk(clk), .rst(rst),
        .i_hdr_we(hdr_we), .i_hdr_addr(hdr_addr), .i_hdr_wdata(hdr_wdata),
        .i_start(start), .i_stop(stop),
        .i_nonce_first(nf), .i_nonce_last(nl), .i_target_lz(tlz),
        .i_h1(h1), .i_h2(h2),
        .o_hash_block(o_hash_block), .o_hash_select(o_hash_select), .o_msg_word(o_msg_word),
        .o_busy(o_busy), .o_done(o_done), .o_found(o_found), .o_aborted(o_aborted),
        .o_found_nonce(o_found_nonce), .o_cur_nonce(o_cur_nonce)
    );

    always #5 clk = ~clk;

    // Stand-in for the hash core: digest is a pure function of the nonce being hashed.
    function automatic logic [63:0] digest(input logic [31:0] n, input int mode, input logic [31:0] k);
        logic [63:0] x;
        if (mode == 0) return (n == 32'h2A) ? 64'h0000_1234_5678_9ABC : {64{1'b1}};
        x = {n ^ k, ~n} * 64'h9E37_79B9_7F4A_7C15;
        return x ^ (x >> 31);
    endfunction

    always_comb {h1, h2} = digest(o_cur_nonce, dmode, key);

    function automatic int lz(input logic [63:0] x);
        for (int i = 63; i >= 0; i--) if (x[i]) return 63 - i;
        return 64;
    endfunction

    function automatic bit hits(input logic [31:0] n, input logic [6:0] t);
        int lim;
        lim = (t > 7'd64) ? 64 : int'(t);
        return lz(digest(n, dmode, key)) >= lim;
    endfunction

    // Expected {busy,done,block,select,msg,nonce} for cycle c after start (c=1 is first BLK0 cycle).
    function automatic logic [95:0] cyc_exp(input int c, input logic [31:0] f);
        int k, p, sel;
        logic [31:0] n, m;
        logic [1:0] b;
        k = (c - 1) / 196;
        p = (c - 1) % 196;
        n = f + 32'(k);
        b = (p < 195) ? 2'(p / 65) : 2'd0;
        sel = (p < 195) ? p % 65 : 0;
        m = (p >= 195 || b == 2'd2) ? 32'd0 : (b == 2'd1 && sel % 16 == 3) ? n : bufm[{b[0], 4'(sel % 16)}];
        return 96'({1'b1, 1'b0, b, 7'(sel), m, n});
    endfunction

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input logic [31:0] f, input logic [31:0] l, input logic [6:0] t,
                         input int stop_c, input int rst_c);
        logic [31:0] n;
        int k, c, done_c;
        bit hit, ab;
        logic [31:0] fn;
        n = f; k = 0; hit = 0;
        forever begin
            if (hits(n, t)) begin hit = 1; break; end
            if (n == l) break;
            n++; k++;
        end
        done_c = (k + 1) * 196 + 1;
        ab = 0;
        fn = hit ? n : 32'd0;
        if (stop_c > 0 && stop_c < done_c) begin
            if (!(stop_c == done_c - 1 && hit)) begin ab = 1; hit = 0; fn = 0; end
            done_c = stop_c + 1;
        end
        nf = f; nl = l; tlz = t; start = 1'b1; c = 0;
        forever begin
            @(posedge clk); #1; c++;
            if (c == 1) start = 1'b0;
            if (c == stop_c + 1) stop = 1'b0;
            if (c == 51) begin start = 1'b0; hdr_we = 1'b0; nf = f; end
            if (o_done || c > done_c + 4) break;
            chk("cycle", 96'({o_busy, o_done, o_hash_block, o_hash_select, o_msg_word, o_cur_nonce}), cyc_exp(c, f));
            if (c == rst_c) begin
                rst = 1'b1; #1;
                chk("reset_mid", 96'({o_busy, o_done, o_hash_block, o_hash_select, o_msg_word, o_cur_nonce, o_found}), 96'(0));
                rst = 1'b0;
                repeat (3) begin
                    @(posedge clk); #1;
                    chk("no_done_after_rst", 96'({o_done, o_busy}), 96'(0));
                end
                return;
            end
            if (c == stop_c) stop = 1'b1;
            if (c == 50) begin start = 1'b1; nf = $urandom; hdr_we = 1'b1; hdr_addr = 5'd7; hdr_wdata = $urandom; end
        end
        start = 1'b0; stop = 1'b0; hdr_we = 1'b0;
        chk("done_cycle", 96'(c), 96'(done_c));
        chk("result", 96'({o_found, o_aborted, o_found_nonce}), 96'({hit, ab, fn}));
        @(posedge clk); #1;
        chk("done_pulse", 96'({o_done, o_busy, o_found_nonce}), 96'({2'b00, fn}));
    endtask

    initial begin
        logic [31:0] f, l;
        logic [6:0] t;
        int sc;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 96'({o_busy, o_done, o_found, o_aborted, o_hash_block, o_hash_select, o_msg_word, o_cur_nonce}), 96'(0));
        chk("reset_found_nonce", 96'(o_found_nonce), 96'(0));
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bufm[i] = $urandom;
            hdr_we = 1'b1; hdr_addr = 5'(i); hdr_wdata = bufm[i];
            @(posedge clk); #1;
        end
        hdr_we = 1'b0;
        sweep(32'd5, 32'd5, 7'd0, -1, -1);
        sweep(32'hFFFF_FFFE, 32'd1, 7'd64, -1, -1);
        sweep(32'h28, 32'h30, 7'd16, -1, -1);
        sweep(32'h100, 32'h110, 7'd64, 140, -1);
        sweep(32'd9, 32'd9, 7'd0, 196, -1);
        sweep(32'd3, 32'd8, 7'd64, -1, 96);
        sweep(32'd7, 32'd7, 7'd0, -1, -1);
        dmode = 1;
        for (int i = 0; i < 8; i++) begin
            key = $urandom;
            f = (i % 2 == 1) ? 32'hFFFF_FFFF - 32'($urandom_range(0, 2)) : $urandom;
            l = f + 32'($urandom_range(0, 3));
            t = (i == 7) ? 7'd100 : 7'($urandom_range(0, 4));
            sc = (i % 3 == 0) ? int'($urandom_range(1, 700)) : -1;
            sweep(f, l, t, sc, -1);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
